// File: rtl/regfile_arb_pkg.sv
// Shared defaults and constants for the register-file write arbiter.
package regfile_arb_pkg;

    localparam int unsigned NUM_REQ_DEFAULT = 3;
    localparam int unsigned ADDR_W_DEFAULT  = 2;
    localparam int unsigned DATA_W_DEFAULT  = 8;

    // Conflict counter width and its saturation value.
    localparam int unsigned        CNT_W   = 8;
    localparam logic [CNT_W-1:0]   CNT_MAX = 8'd255;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first eligible index at or after the pointer.
module rr_picker
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic               o_valid,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] w_sum;
    logic [IDX_W-1:0] w_cand;

    // Scan upward from the pointer with wrap; the first hit wins.
    always_comb begin
        o_valid  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        w_sum    = '0;
        w_cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_rr_ptr} + SUM_W'(k);
            if (w_sum >= SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - SUM_W'(NUM_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!o_valid && i_eligible[w_cand]) begin
                o_valid          = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging several write requesters onto one register-file write port.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       write_enable,
    output logic [ADDR_W-1:0]          write_addr,
    output logic [DATA_W-1:0]          write_data,
    output logic [CNT_W-1:0]           conflict_count
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0] r_gnt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_eligible;
    logic               w_valid;
    logic [NUM_REQ-1:0] w_onehot;
    logic [IDX_W-1:0]   w_idx;
    logic               w_multi;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic [IDX_W-1:0]   w_ptr_next;

    // A requester granted this cycle still holds req; exclude it to avoid a double grant.
    assign w_eligible = req & ~r_gnt;
    assign w_multi    = ($countones(w_eligible) > 1);

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .i_eligible (w_eligible),
        .i_rr_ptr   (r_rr_ptr),
        .o_valid    (w_valid),
        .o_onehot   (w_onehot),
        .o_idx      (w_idx)
    );

    // Route the winner's address/data and compute the pointer just past the winner.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_onehot[i]) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        if (w_idx == IDX_W'(NUM_REQ - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_idx + IDX_W'(1);
        end
    end

    // Registered grant, write port, pointer and saturating conflict counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_valid) begin
                r_gnt    <= w_onehot;
                r_we     <= 1'b1;
                r_addr   <= w_sel_addr;
                r_data   <= w_sel_data;
                r_rr_ptr <= w_ptr_next;
            end else begin
                r_gnt <= '0;
                r_we  <= 1'b0;
            end
            if (w_multi && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign gnt            = r_gnt;
    assign write_enable   = r_we;
    assign write_addr     = r_addr;
    assign write_data     = r_data;
    assign conflict_count = r_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_regfile_write_arbiter;

    localparam int N = 3;
    localparam int A = 2;
    localparam int D = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*A-1:0]   req_addr;
    logic [N*D-1:0]   req_data;
    logic [N-1:0]     gnt;
    logic             write_enable;
    logic [A-1:0]     write_addr;
    logic [D-1:0]     write_data;
    logic [7:0]       conflict_count;

    regfile_write_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (A),
        .DATA_W  (D)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .gnt            (gnt),
        .write_enable   (write_enable),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .conflict_count (conflict_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural reference state.
    int           m_ptr;
    logic [N-1:0] m_gnt;
    logic         m_we;
    logic [A-1:0] m_addr;
    logic [D-1:0] m_data;
    int           m_cnt;

    // Register file written from the DUT's write port.
    logic [D-1:0] rf [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_gnt  = '0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_cnt  = 0;
    endtask

    // One clock edge of the arbiter, computed from the rules directly.
    task automatic model_edge();
        logic [N-1:0] elig;
        int w;
        elig = req & ~m_gnt;
        if ($countones(elig) >= 2 && m_cnt < 255) m_cnt++;
        w = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (w < 0 && elig[idx]) w = idx;
        end
        if (w >= 0) begin
            m_gnt  = '0;
            m_gnt[w] = 1'b1;
            m_we   = 1'b1;
            m_addr = req_addr[w*A +: A];
            m_data = req_data[w*D +: D];
            m_ptr  = (w + 1) % N;
        end else begin
            m_gnt = '0;
            m_we  = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_gnt"},  32'(gnt),            32'(m_gnt));
        chk({tag, "_we"},   32'(write_enable),   32'(m_we));
        chk({tag, "_addr"}, 32'(write_addr),     32'(m_addr));
        chk({tag, "_data"}, 32'(write_data),     32'(m_data));
        chk({tag, "_cnt"},  32'(conflict_count), 32'(m_cnt));
        chk({tag, "_onehot"}, 32'($countones(gnt) <= 1), 32'd1);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        if (write_enable) rf[write_addr] = write_data;
    endtask

    task automatic set_req(input int i, input logic [A-1:0] a, input logic [D-1:0] d);
        req_addr[i*A +: A] = a;
        req_data[i*D +: D] = d;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        req   = '0;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < 4; i++) rf[i] = '0;

        // Reset state.
        do_reset("rst");

        // Single request.
        set_req(0, 2'd2, 8'hA5);
        req = 3'b001;
        tick("single1");
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_addr", 32'(write_addr), 32'h2);
        req = 3'b000;
        tick("single2");
        chk("single_we_low", 32'(write_enable), 32'h0);
        chk("single_rf2", 32'(rf[2]), 32'hA5);

        // All three requesting at once.
        do_reset("rst3");
        set_req(0, 2'd0, 8'h11);
        set_req(1, 2'd1, 8'h22);
        set_req(2, 2'd3, 8'h33);
        req = 3'b111;
        tick("all_a");
        chk("all_g0", 32'(gnt), 32'h1);
        req = req & ~gnt;
        tick("all_b");
        chk("all_g1", 32'(gnt), 32'h2);
        req = req & ~gnt;
        tick("all_c");
        chk("all_g2", 32'(gnt), 32'h4);
        chk("all_we", 32'(write_enable), 32'h1);
        chk("all_cnt", 32'(conflict_count), 32'd2);
        req = req & ~gnt;

        // Rotation after requester 2 was last served.
        set_req(0, 2'd0, 8'h44);
        set_req(2, 2'd2, 8'h66);
        req = 3'b101;
        tick("rot_a");
        chk("rot_g0", 32'(gnt), 32'h1);
        set_req(1, 2'd1, 8'h55);
        req = 3'b110;
        tick("rot_b");
        chk("rot_g1", 32'(gnt), 32'h2);
        req = req & ~gnt;
        tick("rot_c");
        chk("rot_g2", 32'(gnt), 32'h4);
        req = req & ~gnt;
        tick("rot_d");

        // Same target address from two requesters: last writer wins.
        do_reset("rst_same");
        set_req(0, 2'd1, 8'h0F);
        set_req(1, 2'd1, 8'hF0);
        req = 3'b011;
        tick("same_a");
        chk("same_d0", 32'(write_data), 32'h0F);
        req = req & ~gnt;
        tick("same_b");
        chk("same_d1", 32'(write_data), 32'hF0);
        req = req & ~gnt;
        tick("same_c");
        chk("same_rf1", 32'(rf[1]), 32'hF0);

        // Reset mid-operation with all requests held.
        do_reset("rst_mid0");
        set_req(0, 2'd0, 8'hA0);
        set_req(1, 2'd1, 8'hB1);
        set_req(2, 2'd2, 8'hC2);
        req = 3'b111;
        tick("mid_a");
        tick("mid_b");
        chk("mid_we_pre", 32'(write_enable), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_async");
        @(posedge clk);
        #1;
        check_outputs("mid_hold");
        @(negedge clk);
        rst_n = 1'b1;
        tick("mid_post");
        chk("mid_first_gnt", 32'(gnt), 32'h1);

        // Two requesters held continuously: grants alternate.
        do_reset("rst_sat");
        req = 3'b011;
        for (int i = 0; i < 300; i++) begin
            tick("alt");
            chk("alt_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        // Three requesters held continuously: every cycle conflicts, counter saturates.
        req = 3'b111;
        for (int i = 0; i < 300; i++) tick("sat");
        chk("sat_cnt", 32'(conflict_count), 32'd255);

        // Random traffic with withdrawals.
        do_reset("rst_rand");
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && gnt[i]) begin
                    req[i] = 1'b0;
                end else if (req[i] && ($urandom % 20 == 0)) begin
                    req[i] = 1'b0;
                end else if (!req[i] && !gnt[i] && ($urandom % 3 == 0)) begin
                    set_req(i, A'($urandom), D'($urandom));
                    req[i] = 1'b1;
                end
            end
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
